typing_round_controller: RTL and testbench

Sequences one typing game from start to game over. It waits for a start press, runs a countdown, then fetches 4-letter words from the word source through a req/valid handshake. It checks each released-key code against the current letter and enforces a per-word time limit and a miss budget. It sits between the keyboard decoder and the word source, and it replaces ad-hoc key-edge-clocked checking with a single-clock controller.

---
 rtl/typing_round_controller.sv | 176 +++++++++++++++++
 tb/tb_typing_round_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_round_controller.sv
// typing_round_controller
//   Sequences one typing game: IDLE -> COUNTDOWN -> FETCH <-> TYPE -> OVER.
//   Fetches 4-letter words through a req/valid handshake. Checks released-key
//   codes against the current letter. Enforces a per-word time limit and a
//   miss budget. Every output is registered.
//
// Ports
//   i_clk, i_reset      system clock, synchronous active-high reset
//   i_start             one-cycle start pulse (honoured in IDLE and OVER)
//   i_key_valid         one-cycle pulse per released key
//   i_key_code[4:0]     letter code, qualified by i_key_valid
//   o_word_req          request for the next word (high throughout FETCH)
//   i_word_valid        word source has i_word_in ready
//   i_word_in[19:0]     packed word, letter 0 in [19:15] .. letter 3 in [4:0]
//   o_current_word      latched word being typed
//   o_letter_idx        index of the next expected letter
//   o_word_complete     one-cycle pulse after the final letter is matched
//   o_score             completed words this game, saturating at 2047
//   o_misses            wrong keys this game
//   o_game_over         high while in OVER
//   o_over_cause        0 none, 1 misses exhausted, 2 word timeout
//   o_state             IDLE=0, COUNTDOWN=1, FETCH=2, TYPE=3, OVER=4
module typing_round_controller #(
  parameter int WORD_TIMEOUT = 500_000_000,
  parameter int START_DELAY  = 100_000_000,
  parameter int MAX_MISSES   = 3
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_start,
  input  logic                              i_key_valid,
  input  logic [4:0]                        i_key_code,
  output logic                              o_word_req,
  input  logic                              i_word_valid,
  input  logic [19:0]                       i_word_in,
  output logic [19:0]                       o_current_word,
  output logic [1:0]                        o_letter_idx,
  output logic                              o_word_complete,
  output logic [10:0]                       o_score,
  output logic [$clog2(MAX_MISSES+1)-1:0]   o_misses,
  output logic                              o_game_over,
  output logic [1:0]                        o_over_cause,
  output logic [2:0]                        o_state
);

  localparam int MW = $clog2(MAX_MISSES + 1);
  localparam int CW = $clog2(START_DELAY + 1);
  localparam int TW = $clog2(WORD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_FETCH     = 3'd2,
    S_TYPE      = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cd;
  logic [TW-1:0]   r_timer;
  logic [19:0]     r_word;
  logic [1:0]      r_idx;
  logic            r_req;
  logic            r_complete;
  logic [10:0]     r_score;
  logic [MW-1:0]   r_misses;
  logic            r_over;
  logic [1:0]      r_cause;

  logic [4:0]      w_letter;
  logic            w_match;
  logic            w_expire;
  logic [MW-1:0]   w_misses_inc;
  logic            w_miss_out;

  always_comb begin
    w_letter = r_word[19:15];
    case (r_idx)
      2'd1:    w_letter = r_word[14:10];
      2'd2:    w_letter = r_word[9:5];
      2'd3:    w_letter = r_word[4:0];
      default: w_letter = r_word[19:15];
    endcase
    w_match      = (i_key_code == w_letter);
    // Timer holds the cycles left in this word; it hits 0 on this edge when it reads 1.
    w_expire     = (r_timer == TW'(1));
    w_misses_inc = r_misses + MW'(1);
    w_miss_out   = (w_misses_inc == MW'(MAX_MISSES));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cd       <= '0;
      r_timer    <= '0;
      r_word     <= '0;
      r_idx      <= '0;
      r_req      <= 1'b0;
      r_complete <= 1'b0;
      r_score    <= '0;
      r_misses   <= '0;
      r_over     <= 1'b0;
      r_cause    <= '0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (i_start) begin
            r_state  <= S_COUNTDOWN;
            // Loaded with START_DELAY-1 so FETCH begins exactly START_DELAY edges after start.
            r_cd     <= CW'(START_DELAY - 1);
            r_score  <= '0;
            r_misses <= '0;
            r_cause  <= '0;
            r_over   <= 1'b0;
          end
        end
        S_COUNTDOWN: begin
          if (r_cd == '0) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_cd <= r_cd - CW'(1);
          end
        end
        S_FETCH: begin
          if (r_req && i_word_valid) begin
            r_word  <= i_word_in;
            r_idx   <= 2'd0;
            r_timer <= TW'(WORD_TIMEOUT);
            r_state <= S_TYPE;
            r_req   <= 1'b0;
          end
        end
        S_TYPE: begin
          r_timer <= r_timer - TW'(1);
          // Key is resolved before expiry: a completing match beats the timeout,
          // and an exhausting miss reports cause 1 even on the expiry edge.
          if (i_key_valid && w_match && (r_idx == 2'd3)) begin
            r_complete <= 1'b1;
            if (r_score != 11'h7FF) r_score <= r_score + 11'd1;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else if (i_key_valid && !w_match && w_miss_out) begin
            r_misses <= w_misses_inc;
            r_state  <= S_OVER;
            r_cause  <= 2'd1;
            r_over   <= 1'b1;
          end else begin
            if (i_key_valid) begin
              if (w_match) r_idx <= r_idx + 2'd1;
              else         r_misses <= w_misses_inc;
            end
            if (w_expire) begin
              r_state <= S_OVER;
              r_cause <= 2'd2;
              r_over  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_word_req      = r_req;
  assign o_current_word  = r_word;
  assign o_letter_idx    = r_idx;
  assign o_word_complete = r_complete;
  assign o_score         = r_score;
  assign o_misses        = r_misses;
  assign o_game_over     = r_over;
  assign o_over_cause    = r_cause;
  assign o_state         = r_state;

endmodule

// File: tb/tb_typing_round_controller.sv
module tb_typing_round_controller;

  localparam int START_DELAY  = 4;
  localparam int WORD_TIMEOUT = 20;
  localparam int MAX_MISSES   = 2;
  localparam int MW = $clog2(MAX_MISSES + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          kv = 1'b0;
  logic [4:0]    kc = '0;
  logic          wv = 1'b0;
  logic [19:0]   wi = '0;
  logic          o_word_req;
  logic [19:0]   o_current_word;
  logic [1:0]    o_letter_idx;
  logic          o_word_complete;
  logic [10:0]   o_score;
  logic [MW-1:0] o_misses;
  logic          o_game_over;
  logic [1:0]    o_over_cause;
  logic [2:0]    o_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: game rules expressed with absolute edge deadlines.
  int          m_state, m_idx, m_score, m_misses, m_cause, m_req, m_complete, m_over;
  logic [19:0] m_word;
  int          m_fetch_at, m_deadline;

  typing_round_controller #(
    .WORD_TIMEOUT(WORD_TIMEOUT), .START_DELAY(START_DELAY), .MAX_MISSES(MAX_MISSES)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_key_valid(kv), .i_key_code(kc),
    .o_word_req(o_word_req), .i_word_valid(wv), .i_word_in(wi),
    .o_current_word(o_current_word), .o_letter_idx(o_letter_idx),
    .o_word_complete(o_word_complete), .o_score(o_score), .o_misses(o_misses),
    .o_game_over(o_game_over), .o_over_cause(o_over_cause), .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] letter_of(input logic [19:0] w, input int i);
    return 5'((w >> (5 * (3 - i))) & 20'h1F);
  endfunction

  task automatic model_edge(input int e);
    bit done;
    done = 0;
    m_complete = 0;
    if (rst) begin
      m_state = 0; m_idx = 0; m_score = 0; m_misses = 0; m_cause = 0;
      m_req = 0; m_over = 0; m_word = '0;
      return;
    end
    case (m_state)
      0, 4: if (start) begin
        m_state = 1; m_score = 0; m_misses = 0; m_cause = 0; m_over = 0;
        m_fetch_at = e + START_DELAY;
      end
      1: if (e == m_fetch_at) begin m_state = 2; m_req = 1; end
      2: if (wv) begin
        m_word = wi; m_idx = 0; m_deadline = e + WORD_TIMEOUT; m_state = 3; m_req = 0;
      end
      3: begin
        if (kv) begin
          if (kc == letter_of(m_word, m_idx)) begin
            if (m_idx == 3) begin
              m_complete = 1;
              if (m_score < 2047) m_score++;
              m_state = 2; m_req = 1; done = 1;
            end else m_idx++;
          end else begin
            m_misses++;
            if (m_misses == MAX_MISSES) begin m_state = 4; m_cause = 1; m_over = 1; done = 1; end
          end
        end
        if (!done && e == m_deadline) begin m_state = 4; m_cause = 2; m_over = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    model_edge(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic key(input logic [4:0] code);
    kv = 1'b1; kc = code; tick(); kv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; kv = 0; kc = 0; wv = 0; wi = 0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (o_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", o_state); end
    tests++; if (o_word_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", o_word_req); end
    tests++; if (o_current_word !== 20'h0) begin fails++; $display("FAIL reset_word: got %h want 0", o_current_word); end
    tests++; if (o_score !== 11'd0 || o_misses !== '0 || o_over_cause !== 2'd0) begin fails++;
      $display("FAIL reset_counters: got score %0d misses %0d cause %0d want 0 0 0", o_score, o_misses, o_over_cause); end
    tests++; if (o_game_over !== 1'b0 || o_letter_idx !== 2'd0 || o_word_complete !== 1'b0) begin fails++;
      $display("FAIL reset_flags: got over %b idx %0d wc %b want 0 0 0", o_game_over, o_letter_idx, o_word_complete); end
  endtask

  task automatic test_full_word();
    wi = 20'h08C64; wv = 1'b1;
    pulse_start();
    tests++; if (o_state !== 3'd1) begin fails++; $display("FAIL fw_countdown: got %0d want 1", o_state); end
    repeat (START_DELAY - 1) tick();
    tests++; if (o_state !== 3'd1) begin fails++; $display("FAIL fw_countdown_len: got %0d want 1", o_state); end
    tick();
    tests++; if (o_state !== 3'd2 || o_word_req !== 1'b1) begin fails++;
      $display("FAIL fw_fetch: got state %0d req %b want 2 1", o_state, o_word_req); end
    tick();
    tests++; if (o_state !== 3'd3 || o_current_word !== 20'h08C64 || o_letter_idx !== 2'd0 || o_word_req !== 1'b0) begin fails++;
      $display("FAIL fw_accept: got state %0d word %h idx %0d req %b want 3 08c64 0 0", o_state, o_current_word, o_letter_idx, o_word_req); end
    key(5'd1);
    tests++; if (o_letter_idx !== 2'd1) begin fails++; $display("FAIL fw_idx1: got %0d want 1", o_letter_idx); end
    tick(); key(5'd3);
    tests++; if (o_letter_idx !== 2'd2) begin fails++; $display("FAIL fw_idx2: got %0d want 2", o_letter_idx); end
    tick(); key(5'd3);
    tests++; if (o_letter_idx !== 2'd3 || o_word_complete !== 1'b0) begin fails++;
      $display("FAIL fw_idx3: got idx %0d wc %b want 3 0", o_letter_idx, o_word_complete); end
    tick(); key(5'd4);
    tests++; if (o_word_complete !== 1'b1 || o_score !== 11'd1 || o_state !== 3'd2) begin fails++;
      $display("FAIL fw_complete: got wc %b score %0d state %0d want 1 1 2", o_word_complete, o_score, o_state); end
    tick();
    tests++; if (o_word_complete !== 1'b0 || o_state !== 3'd3) begin fails++;
      $display("FAIL fw_pulse_width: got wc %b state %0d want 0 3", o_word_complete, o_state); end
  endtask

  task automatic test_miss_budget();
    key(5'd2);
    tests++; if (o_misses !== MW'(1) || o_letter_idx !== 2'd0) begin fails++;
      $display("FAIL mb_miss1: got misses %0d idx %0d want 1 0", o_misses, o_letter_idx); end
    key(5'd1);
    tests++; if (o_letter_idx !== 2'd1 || o_misses !== MW'(1)) begin fails++;
      $display("FAIL mb_idx: got idx %0d misses %0d want 1 1", o_letter_idx, o_misses); end
    key(5'd5);
    tests++; if (o_game_over !== 1'b1 || o_over_cause !== 2'd1 || o_state !== 3'd4 || o_score !== 11'd1) begin fails++;
      $display("FAIL mb_over: got over %b cause %0d state %0d score %0d want 1 1 4 1", o_game_over, o_over_cause, o_state, o_score); end
    key(5'd0);
    tests++; if (o_misses !== MW'(2) || o_state !== 3'd4) begin fails++;
      $display("FAIL mb_hold: got misses %0d state %0d want 2 4", o_misses, o_state); end
  endtask

  task automatic test_back_to_back_timeout();
    pulse_start();
    tests++; if (o_state !== 3'd1 || o_score !== 11'd0 || o_misses !== '0 || o_over_cause !== 2'd0 || o_game_over !== 1'b0) begin fails++;
      $display("FAIL restart: got state %0d score %0d misses %0d cause %0d over %b want 1 0 0 0 0", o_state, o_score, o_misses, o_over_cause, o_game_over); end
    repeat (START_DELAY) tick();
    tick();
    key(5'd1); key(5'd3); key(5'd3);
    tests++; if (o_letter_idx !== 2'd3) begin fails++; $display("FAIL b2b_idx: got %0d want 3", o_letter_idx); end
    key(5'd4);
    tests++; if (o_score !== 11'd1 || o_state !== 3'd2 || o_word_complete !== 1'b1) begin fails++;
      $display("FAIL b2b_complete: got score %0d state %0d wc %b want 1 2 1", o_score, o_state, o_word_complete); end
    tick();
    repeat (WORD_TIMEOUT - 1) tick();
    tests++; if (o_state !== 3'd3) begin fails++; $display("FAIL to_early: got %0d want 3", o_state); end
    tick();
    tests++; if (o_state !== 3'd4 || o_over_cause !== 2'd2 || o_score !== 11'd1 || o_game_over !== 1'b1) begin fails++;
      $display("FAIL to_over: got state %0d cause %0d score %0d over %b want 4 2 1 1", o_state, o_over_cause, o_score, o_game_over); end
  endtask

  task automatic test_simultaneous();
    pulse_start();
    repeat (START_DELAY) tick();
    tick();
    key(5'd1); key(5'd3); key(5'd3);
    repeat (WORD_TIMEOUT - 4) tick();
    tests++; if (o_state !== 3'd3) begin fails++; $display("FAIL sim_pre: got %0d want 3", o_state); end
    key(5'd4);
    tests++; if (o_state !== 3'd2 || o_score !== 11'd1 || o_game_over !== 1'b0) begin fails++;
      $display("FAIL sim_final_key: got state %0d score %0d over %b want 2 1 0", o_state, o_score, o_game_over); end
    tick();
    repeat (WORD_TIMEOUT - 1) tick();
    tests++; if (o_state !== 3'd3) begin fails++; $display("FAIL sim_pre2: got %0d want 3", o_state); end
    key(5'd1);
    tests++; if (o_state !== 3'd4 || o_over_cause !== 2'd2) begin fails++;
      $display("FAIL sim_partial_key: got state %0d cause %0d want 4 2", o_state, o_over_cause); end
  endtask

  task automatic test_stall_reset();
    wv = 1'b0;
    pulse_start();
    repeat (START_DELAY) tick();
    wi = 20'hFFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (o_word_req !== 1'b1 || o_state !== 3'd2 || o_current_word !== 20'h08C64) begin fails++;
        $display("FAIL stall_%0d: got req %b state %0d word %h want 1 2 08c64", i, o_word_req, o_state, o_current_word); end
    end
    rst = 1'b1; wv = 1'b1; tick(); rst = 1'b0;
    tests++; if (o_state !== 3'd0 || o_word_req !== 1'b0 || o_current_word !== 20'h0 || o_score !== 11'd0 || o_misses !== '0 ||
                 o_over_cause !== 2'd0 || o_game_over !== 1'b0 || o_letter_idx !== 2'd0 || o_word_complete !== 1'b0) begin fails++;
      $display("FAIL midfetch_reset: got state %0d req %b word %h score %0d misses %0d cause %0d want all 0",
               o_state, o_word_req, o_current_word, o_score, o_misses, o_over_cause); end
  endtask

  task automatic test_saturation();
    wi = 20'h0; wv = 1'b1; kc = 5'd0;
    pulse_start();
    repeat (START_DELAY) tick();
    for (int n = 1; n <= 2048; n++) begin
      tick();
      kv = 1'b1; repeat (4) tick(); kv = 1'b0;
      if (n == 2047) begin
        tests++; if (o_score !== 11'd2047) begin fails++; $display("FAIL sat_2047: got %0d want 2047", o_score); end
      end
    end
    tests++; if (o_score !== 11'd2047 || o_state !== 3'd2 || o_misses !== '0) begin fails++;
      $display("FAIL sat_hold: got score %0d state %0d misses %0d want 2047 2 0", o_score, o_state, o_misses); end
  endtask

  task automatic test_random();
    rst = 1'b1; kv = 0; start = 0; tick(); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      kv    = ($urandom_range(0, 2) == 0);
      kc    = ($urandom_range(0, 1) == 0) ? letter_of(m_word, m_idx) : 5'($urandom_range(0, 31));
      wv    = ($urandom_range(0, 1) == 0);
      wi    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rst   = ($urandom_range(0, 399) == 0);
      tick();
      tests++; if (o_state !== 3'(m_state) || o_word_req !== 1'(m_req) || o_game_over !== 1'(m_over)) begin fails++;
        $display("FAIL rnd_ctrl cyc %0d: got state %0d req %b over %b want %0d %0d %0d", cyc, o_state, o_word_req, o_game_over, m_state, m_req, m_over); end
      tests++; if (o_score !== 11'(m_score) || o_misses !== MW'(m_misses) || o_over_cause !== 2'(m_cause)) begin fails++;
        $display("FAIL rnd_count cyc %0d: got score %0d misses %0d cause %0d want %0d %0d %0d", cyc, o_score, o_misses, o_over_cause, m_score, m_misses, m_cause); end
      tests++; if (o_letter_idx !== 2'(m_idx) || o_word_complete !== 1'(m_complete) || o_current_word !== m_word) begin fails++;
        $display("FAIL rnd_word cyc %0d: got idx %0d wc %b word %h want %0d %0d %h", cyc, o_letter_idx, o_word_complete, o_current_word, m_idx, m_complete, m_word); end
    end
    rst = 1'b0; kv = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_miss_budget();
    test_back_to_back_timeout();
    test_simultaneous();
    test_stall_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
